uart_tx_arbiter: RTL and testbench

Shares the single on-chip UART transmitter that drives FPGA_SERIAL_TX between two byte-stream requesters: the CPU's memory-mapped UART path (requester 0) and a hardware status/debug reporter (requester 1). A three-state grant FSM performs round-robin arbitration with packet locking, a per-grant byte quota, and a gap timeout, so neither source can starve the other or interleave bytes mid-packet. It sits between the requesters and the uart_transmitter byte interface inside the CPU clock domain.

---
 rtl/uart_tx_arbiter_if.sv | 34 +++
 rtl/uart_tx_arbiter.sv | 129 ++++++++++++
 tb/tb_uart_tx_arbiter.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Byte-stream bundle between the two UART requesters, the shared transmitter and the arbiter.
// The slave modport is the arbiter's view; the master modport is the surrounding logic.
interface uart_tx_arbiter_if;
  logic [7:0] req0_data;
  logic       req0_valid;
  logic       req0_last;
  logic       req0_ready;
  logic [7:0] req1_data;
  logic       req1_valid;
  logic       req1_last;
  logic       req1_ready;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [1:0] grant;

  modport slave (
    input  req0_data, req0_valid, req0_last,
    input  req1_data, req1_valid, req1_last,
    input  tx_ready,
    output req0_ready, req1_ready,
    output tx_data, tx_valid,
    output grant
  );

  modport master (
    output req0_data, req0_valid, req0_last,
    output req1_data, req1_valid, req1_last,
    output tx_ready,
    input  req0_ready, req1_ready,
    input  tx_data, tx_valid,
    input  grant
  );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between two byte-stream requesters,
// with packet locking, a per-grant byte quota and a valid-gap timeout.
module uart_tx_arbiter #(
  parameter int unsigned MAX_HOLD    = 16,
  parameter int unsigned GAP_TIMEOUT = 64
) (
  input logic                  clk,
  input logic                  rst_n,
  uart_tx_arbiter_if.slave     bus
);

  localparam int unsigned HoldW = $clog2(MAX_HOLD + 1);
  localparam int unsigned GapW  = $clog2(GAP_TIMEOUT + 1);
  localparam logic [HoldW-1:0] HoldMax = HoldW'(MAX_HOLD);
  localparam logic [GapW-1:0]  GapMax  = GapW'(GAP_TIMEOUT);

  typedef enum logic [1:0] {StIdle, StGnt0, StGnt1} state_e;

  state_e           state_q, state_d;
  logic             last_served_q, last_served_d;
  logic [HoldW-1:0] hold_cnt_q, hold_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;

  logic             own_valid, own_last, other_valid, xfer, release_grant;
  logic [HoldW-1:0] hold_inc;
  logic [GapW-1:0]  gap_inc;

  // Outputs decode from state only, so reset drops the grant without waiting for a clock.
  always_comb begin
    bus.tx_valid   = 1'b0;
    bus.tx_data    = 8'h00;
    bus.req0_ready = 1'b0;
    bus.req1_ready = 1'b0;
    bus.grant      = 2'b00;
    unique case (state_q)
      StGnt0: begin
        bus.tx_valid   = bus.req0_valid;
        bus.tx_data    = bus.req0_data;
        bus.req0_ready = bus.tx_ready;
        bus.grant      = 2'b01;
      end
      StGnt1: begin
        bus.tx_valid   = bus.req1_valid;
        bus.tx_data    = bus.req1_data;
        bus.req1_ready = bus.tx_ready;
        bus.grant      = 2'b10;
      end
      default: ;
    endcase
  end

  always_comb begin
    own_valid   = 1'b0;
    own_last    = 1'b0;
    other_valid = 1'b0;
    unique case (state_q)
      StGnt0: begin
        own_valid   = bus.req0_valid;
        own_last    = bus.req0_last;
        other_valid = bus.req1_valid;
      end
      StGnt1: begin
        own_valid   = bus.req1_valid;
        own_last    = bus.req1_last;
        other_valid = bus.req0_valid;
      end
      default: ;
    endcase
    xfer     = own_valid & bus.tx_ready;
    hold_inc = (hold_cnt_q == HoldMax) ? hold_cnt_q : hold_cnt_q + HoldW'(1);
    gap_inc  = (gap_cnt_q == GapMax) ? gap_cnt_q : gap_cnt_q + GapW'(1);
    // A saturated quota keeps firing, so rotation happens on the first transfer the
    // other requester is waiting for.
    release_grant = (xfer & (own_last | ((hold_inc == HoldMax) & other_valid)))
                  | (~own_valid & (gap_inc == GapMax));
  end

  always_comb begin
    state_d       = state_q;
    last_served_d = last_served_q;
    hold_cnt_d    = hold_cnt_q;
    gap_cnt_d     = gap_cnt_q;
    unique case (state_q)
      StIdle: begin
        hold_cnt_d = '0;
        gap_cnt_d  = '0;
        if (bus.req0_valid && (!bus.req1_valid || last_served_q)) begin
          state_d = StGnt0;
        end else if (bus.req1_valid) begin
          state_d = StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        if (xfer) begin
          hold_cnt_d = hold_inc;
          gap_cnt_d  = '0;
        end else if (!own_valid) begin
          gap_cnt_d = gap_inc;
        end
        if (release_grant) begin
          last_served_d = (state_q == StGnt1);
          hold_cnt_d    = '0;
          gap_cnt_d     = '0;
          if (other_valid) begin
            state_d = (state_q == StGnt0) ? StGnt1 : StGnt0;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      last_served_q <= 1'b1;
      hold_cnt_q    <= '0;
      gap_cnt_q     <= '0;
    end else begin
      state_q       <= state_d;
      last_served_q <= last_served_d;
      hold_cnt_q    <= hold_cnt_d;
      gap_cnt_q     <= gap_cnt_d;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic, all cycles checked
// against a cycle-level reference model of the arbitration rules.
module tb_uart_tx_arbiter;

  localparam int MaxHold    = 16;
  localparam int GapTimeout = 64;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  uart_tx_arbiter_if bus();

  uart_tx_arbiter #(
    .MAX_HOLD    (MaxHold),
    .GAP_TIMEOUT (GapTimeout)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Requester sources: {last, data} per entry; en gates valid to create gaps.
  logic [8:0] q0[$];
  logic [8:0] q1[$];
  bit en0 = 1'b1;
  bit en1 = 1'b1;
  bit rdy = 1'b1;

  // Reference model: owner -1 = nobody, held = bytes sent this grant, gap = idle cycles.
  int m_owner = -1;
  int m_held  = 0;
  int m_gap   = 0;
  int m_last  = 1;

  logic [1:0] s_grant;
  logic [7:0] s_data;
  logic       s_valid, s_r0, s_r1;

  task automatic model_reset();
    m_owner = -1;
    m_held  = 0;
    m_gap   = 0;
    m_last  = 1;
  endtask

  // Entered at posedge+1; drives inputs, samples and checks mid-cycle, advances the model.
  task automatic tick();
    bit v[2];
    bit l[2];
    logic [7:0] d[2];
    logic [8:0] h0, h1;
    logic [1:0] e_grant;
    logic [7:0] e_data;
    bit e_valid, e_r0, e_r1, xfer, rel;
    int x, o;
    h0 = (q0.size() > 0) ? q0[0] : 9'h000;
    h1 = (q1.size() > 0) ? q1[0] : 9'h000;
    v[0] = en0 && (q0.size() > 0);
    v[1] = en1 && (q1.size() > 0);
    d[0] = h0[7:0];
    d[1] = h1[7:0];
    l[0] = h0[8];
    l[1] = h1[8];
    bus.req0_valid = v[0];
    bus.req0_data  = d[0];
    bus.req0_last  = l[0];
    bus.req1_valid = v[1];
    bus.req1_data  = d[1];
    bus.req1_last  = l[1];
    bus.tx_ready   = rdy;
    #3;
    s_grant = bus.grant;
    s_data  = bus.tx_data;
    s_valid = bus.tx_valid;
    s_r0    = bus.req0_ready;
    s_r1    = bus.req1_ready;
    e_grant = 2'b00;
    e_data  = 8'h00;
    e_valid = 1'b0;
    e_r0    = 1'b0;
    e_r1    = 1'b0;
    if (m_owner >= 0) begin
      e_grant = (m_owner == 0) ? 2'b01 : 2'b10;
      e_data  = d[m_owner];
      e_valid = v[m_owner];
      e_r0    = (m_owner == 0) && rdy;
      e_r1    = (m_owner == 1) && rdy;
    end
    check_eq("grant", s_grant, e_grant);
    check_eq("tx_valid", s_valid, e_valid);
    check_eq("tx_data", s_data, e_data);
    check_eq("req0_ready", s_r0, e_r0);
    check_eq("req1_ready", s_r1, e_r1);

    if (m_owner < 0) begin
      if (v[0] && v[1]) m_owner = (m_last == 1) ? 0 : 1;
      else if (v[0]) m_owner = 0;
      else if (v[1]) m_owner = 1;
      m_held = 0;
      m_gap  = 0;
    end else begin
      x = m_owner;
      o = 1 - x;
      rel = 1'b0;
      xfer = v[x] && rdy;
      if (xfer) begin
        if (m_held < MaxHold) m_held++;
        m_gap = 0;
        if (l[x]) rel = 1'b1;
        if (m_held == MaxHold && v[o]) rel = 1'b1;
        if (x == 0) void'(q0.pop_front());
        else void'(q1.pop_front());
      end else if (!v[x]) begin
        if (m_gap < GapTimeout) m_gap++;
        if (m_gap == GapTimeout) rel = 1'b1;
      end
      if (rel) begin
        m_last  = x;
        m_owner = v[o] ? o : -1;
        m_held  = 0;
        m_gap   = 0;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    q0.delete();
    q1.delete();
    en0 = 1'b1;
    en1 = 1'b1;
    rdy = 1'b1;
    bus.req0_valid = 1'b0;
    bus.req0_data  = 8'h00;
    bus.req0_last  = 1'b0;
    bus.req1_valid = 1'b0;
    bus.req1_data  = 8'h00;
    bus.req1_last  = 1'b0;
    bus.tx_ready   = 1'b1;
    model_reset();
    #1;
    check_eq("rst_grant", bus.grant, 2'b00);
    check_eq("rst_tx_valid", bus.tx_valid, 1'b0);
    check_eq("rst_tx_data", bus.tx_data, 8'h00);
    check_eq("rst_ready", {bus.req0_ready, bus.req1_ready}, 2'b00);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic push_packet(input int who, input int len, input bit with_last);
    for (int i = 0; i < len; i++) begin
      logic [8:0] e;
      e = {with_last && (i == len - 1), 8'($urandom)};
      if (who == 0) q0.push_back(e);
      else q1.push_back(e);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int cnt;
    logic [7:0] held_byte;

    // Single 3-byte packet from requester 0.
    do_reset();
    q0.push_back(9'h041);
    q0.push_back(9'h042);
    q0.push_back(9'h143);
    tick();
    check_eq("t1_c0_grant", s_grant, 2'b00);
    tick();
    check_eq("t1_c1_grant", s_grant, 2'b01);
    check_eq("t1_c1_data", s_data, 8'h41);
    tick();
    check_eq("t1_c2_data", s_data, 8'h42);
    tick();
    check_eq("t1_c3_data", s_data, 8'h43);
    tick();
    check_eq("t1_c4_grant", s_grant, 2'b00);

    // Tie after reset goes to requester 0, then switches without a bubble.
    do_reset();
    q0.push_back(9'h111);
    q1.push_back(9'h122);
    tick();
    tick();
    check_eq("t2_first_grant", s_grant, 2'b01);
    check_eq("t2_first_data", s_data, 8'h11);
    tick();
    check_eq("t2_switch_grant", s_grant, 2'b10);
    check_eq("t2_switch_data", s_data, 8'h22);
    tick();
    check_eq("t2_idle_grant", s_grant, 2'b00);

    // Quota rotation with the other requester waiting.
    do_reset();
    push_packet(0, 40, 1'b0);
    push_packet(1, 3, 1'b1);
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (s_grant == 2'b10) break;
      if (s_grant == 2'b01 && s_valid) cnt++;
    end
    check_eq("t3_quota_xfers", cnt, MaxHold);
    check_eq("t3_quota_rotate", s_grant, 2'b10);

    // Alone past the quota, rotation on the first transfer that sees requester 1.
    do_reset();
    push_packet(0, 25, 1'b0);
    cnt = 0;
    for (int c = 0; c < 60 && cnt < 20; c++) begin
      tick();
      if (s_grant == 2'b01 && s_valid) cnt++;
    end
    check_eq("t4_solo_xfers", cnt, 20);
    check_eq("t4_solo_grant", s_grant, 2'b01);
    q1.push_back(9'h1a5);
    tick();
    check_eq("t4_byte21_grant", s_grant, 2'b01);
    tick();
    check_eq("t4_rotate_grant", s_grant, 2'b10);

    // Gap timeout with requester 1 waiting.
    do_reset();
    push_packet(0, 3, 1'b0);
    q1.push_back(9'h133);
    tick();
    tick();
    en0 = 1'b0;
    cnt = 0;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (s_grant != 2'b01) break;
      cnt++;
    end
    check_eq("t5_gap_cycles", cnt, GapTimeout);
    check_eq("t5_gap_grant", s_grant, 2'b10);

    // Reasserting after 63 idle cycles keeps the packet lock.
    do_reset();
    push_packet(0, 3, 1'b0);
    q1.push_back(9'h133);
    tick();
    tick();
    en0 = 1'b0;
    repeat (GapTimeout - 1) tick();
    check_eq("t5_gap63_grant", s_grant, 2'b01);
    en0 = 1'b1;
    tick();
    check_eq("t5_reassert_grant", s_grant, 2'b01);
    tick();
    check_eq("t5_kept_grant", s_grant, 2'b01);

    // Transmitter back-pressure mid-packet, then asynchronous reset.
    do_reset();
    push_packet(0, 6, 1'b1);
    tick();
    tick();
    rdy = 1'b0;
    held_byte = q0[0][7:0];
    for (int c = 0; c < 10; c++) begin
      tick();
      check_eq("t6_stall_valid", s_valid, 1'b1);
      check_eq("t6_stall_data", s_data, held_byte);
      check_eq("t6_stall_ready", s_r0, 1'b0);
    end
    rdy = 1'b1;
    tick();
    check_eq("t6_resume_data", s_data, held_byte);
    tick();
    rst_n = 1'b0;
    #1;
    check_eq("t6_async_grant", bus.grant, 2'b00);
    check_eq("t6_async_valid", bus.tx_valid, 1'b0);

    // Random traffic against the model.
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      if (q0.size() < 2 && ($urandom % 4) == 0) push_packet(0, $urandom_range(1, 24), 1'b1);
      if (q1.size() < 2 && ($urandom % 4) == 0) push_packet(1, $urandom_range(1, 24), 1'b1);
      en0 = ($urandom % 8) != 0;
      en1 = ($urandom % 8) != 0;
      rdy = ($urandom % 4) != 0;
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
